lsu_bus_bridge: RTL

//  Load/store bus bridge downstream of the multicycle control unit and datapath: consumes busWe, LSControl,

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_bus_bridge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and access-legality helper for the LSU bus bridge.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Illegal size encoding or an address not naturally aligned to the size.
    function automatic logic ls_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            LS_BYTE: bad = 1'b0;
            LS_HALF: bad = addr_lo[0];
            LS_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Brief  : Store lane replication/strobes and load lane extract/extension.
// Rev    : 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b0000;
        case (st_size)
            LS_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            LS_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            LS_WORD: st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_data = ld_rdata;
        case (ld_size)
            LS_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            LS_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module : lsu_bus_bridge
// Brief  : One data-memory transaction per CPU request over a valid/ready bus.
// Rev    : 1.0
// ============================================================================
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  LSControl,
    input  logic        SignControl,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      ld_data;

    lsu_lane_align u_align (
        .st_size     (LSControl),
        .st_addr_lo  (cpu_addr[1:0]),
        .st_data     (cpu_wdata),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_size     (size_q),
        .ld_addr_lo  (addr_q[1:0]),
        .ld_unsigned (uns_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    size_d  = LSControl;
                    uns_d   = SignControl;
                    wdata_d = st_wdata;
                    wstrb_d = cpu_we ? st_wstrb : 4'b0000;
                    cnt_d   = '0;
                    if (ls_illegal(LSControl, cpu_addr[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A ready arriving on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!we_q) rdata_d = ld_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_valid = (state_q == REQ);
    assign cpu_ready = (state_q == DONE);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;

endmodule
`default_nettype wire
